i2c_target_engine: RTL
======================

Name: i2c_target_engine

Overview:
- Bit-level I2C target (responder) engine: the far end of an I2C host bus segment.
- Watches SCL/SDA through synchronizers and detects START/STOP.
- Matches a fixed 7-bit address and ACKs it, then receives write bytes into a valid/ready stream or transmits read bytes from one.
- Stretches SCL when the stream side is not ready; drives pins open-drain style.

Parameters:
- TargetAddr, 7'h50, 7-bit address answered; must be nonzero (general call 0x00 is never matched).
- SyncStages, 2, flops in each SCL/SDA input synchronizer (≥2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- enable_i  in  1  engine enable; low forces Idle with pins released
- scl_i  in  1  bus SCL
- sda_i  in  1  bus SDA
- scl_o  out  1  0 = pull SCL low (stretch), 1 = release
- sda_o  out  1  0 = pull SDA low, 1 = release
- rx_data_o  out  8  received write byte
- rx_first_o  out  1  rx_data_o is the first byte after address
- rx_valid_o  out  1  rx_data_o valid
- rx_ready_i  in  1  consumer accepts rx byte
- tx_data_i  in  8  byte to send on read
- tx_valid_i  in  1  tx_data_i valid
- tx_ready_o  out  1  one-cycle accept of tx_data_i (handshake when tx_valid_i & tx_ready_o)
- stop_o  out  1  one-cycle pulse: STOP seen while addressed
- nak_o  out  1  one-cycle pulse: host NAKed a read byte
- busy_o  out  1  addressed (any state other than Idle/Wait)

Behaviour:
- Reset values: scl_o=1, sda_o=1, rx_data_o=0, rx_first_o=0, rx_valid_o=0, tx_ready_o=0, stop_o=0, nak_o=0, busy_o=0; state Idle. Synchronizer flops reset to 1.
- Edges are derived from synchronized values compared against their 1-cycle-delayed copies.
- Pin response is ≤ SyncStages+1 cycles after a bus edge. The bus SCL low phase must be ≥ SyncStages+3 clk cycles.
- START = SDA fall while SCL high. STOP = SDA rise while SCL high.
- START/STOP take priority over bit processing in the same cycle.
- START from any state (repeated START included): go to Addr, clear bit count, release sda_o/scl_o.
- STOP from any state: go to Idle, release pins. Pulse stop_o if busy_o was 1.
- enable_i=0: Idle immediately, pins released. A held rx_valid_o stays until accepted.
- Addr: shift SDA on each SCL rise, MSB first. On the SCL fall after the 8th bit:
  - byte[7:1]==TargetAddr: go AddrAck and set sda_o=0.
  - Otherwise: go Wait with sda released.
- Wait: ignore everything except START/STOP.
- AddrAck: on the next SCL fall, release sda and branch on R/W. R/W=0 → RxByte with rx_first pending. R/W=1 → TxLoad.
- RxByte: shift 8 bits on SCL rises. On the 8th-bit SCL fall:
  - rx_valid_o=0: load rx_data_o, set rx_valid_o=1, rx_first_o = pending flag (then cleared), sda_o=0 (ACK), go RxAck.
  - rx_valid_o=1: scl_o=0 (stretch) until the rx handshake completes. In the cycle after rx_valid_o drops, load, ACK, release scl_o.
- RxAck: on the next SCL fall, release sda, go RxByte.
- rx_valid_o clears on the cycle rx_valid_o & rx_ready_i is seen. Data is stable while valid.
- TxLoad (SCL is low): scl_o=0 while tx_valid_i=0.
  - When tx_valid_i=1: tx_ready_o=1 for one cycle, load shifter, sda_o=MSB, release scl_o, go TxByte.
- TxByte: on each SCL fall shift out the next bit. On the fall after bit 0: release sda, go TxAck.
- TxAck: sample SDA on SCL rise.
  - 0 (ACK): on the next fall go TxLoad.
  - 1 (NAK): pulse nak_o, go Wait.
- Bit counter is 3-bit plus done flag. No wrap beyond 8.

Optional Feature:
- Macro I2C_TARGET_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter follows each synchronizer. Single-cycle pin glitches are suppressed; edge latency +2 cycles; minimum SCL low phase rises to SyncStages+5.
- Undefined: synchronizer output is used directly.

Test Plan:
- Write 0x50, W + bytes 0xA5,0x3C, rx_ready_i=1, STOP → ACKs after the address and both bytes; rx_data_o 0xA5 (rx_first_o=1) then 0x3C (rx_first_o=0); one stop_o pulse.
- Address 0x51 W + byte → sda_o stays 1 throughout; no rx_valid_o; no stop_o on STOP; busy_o=0.
- Read 0x50, R with tx_valid_i=0 for 40 cycles, then tx_data_i=0xC3 → scl_o=0 until tx_valid_i; SDA bits 1,1,0,0,0,0,1,1; host NAK → nak_o pulse, state Wait.
- Write 2 bytes with rx_ready_i=0 → first byte ACKed; SCL held low after the 2nd byte's 8th bit. Raise rx_ready_i → 2nd byte loaded, ACK, scl_o released.
- Repeated START mid-write then 0x50,R; also STOP mid-byte; also rst_ni low mid-read → correct Addr/Idle transitions; pins released; outputs at reset values.
- With I2C_TARGET_GLITCH_FILTER_EN: 1-cycle SDA low pulse while SCL high → no START detected.

Source files
------------

// File: rtl/i2c_target_engine.sv
// rtl/i2c_target_engine.sv - I2C target bit engine: address match, rx/tx byte streams, SCL stretching
//
// Optional build macro: I2C_TARGET_GLITCH_FILTER_EN (3-sample majority filter after each synchronizer)
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   enable_i                 engine enable; low forces Idle with pins released
//   scl_i, sda_i             bus lines (asynchronous)
//   scl_o, sda_o             open-drain drives: 0 pulls the line low, 1 releases
//   rx_data_o/first/valid    received write byte stream, rx_ready_i accepts
//   tx_data_i/valid          read byte stream, tx_ready_o is a one-cycle accept
//   stop_o, nak_o, busy_o    STOP-while-addressed pulse, host NAK pulse, addressed flag
module i2c_target_engine #(
  parameter logic [6:0] TargetAddr = 7'h50,
  parameter int         SyncStages = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic [7:0] rx_data_o,
  output logic       rx_first_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       stop_o,
  output logic       nak_o,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_WAIT, S_ADDR_ACK, S_RX_BYTE, S_RX_STALL,
    S_RX_ACK, S_TX_LOAD, S_TX_BYTE, S_TX_ACK
  } state_t;

  logic [SyncStages-1:0] scl_sync, sda_sync;
  logic                  scl_f, sda_f;
  logic                  scl_d, sda_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SyncStages-2:0], scl_i};
      sda_sync <= {sda_sync[SyncStages-2:0], sda_i};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  // Majority of the current and two previous samples, registered: a single-cycle
  // pulse never wins the vote.
  logic [1:0] scl_hist, sda_hist;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[SyncStages-1]};
      sda_hist <= {sda_hist[0], sda_sync[SyncStages-1]};
      scl_f    <= (scl_sync[SyncStages-1] & scl_hist[0]) | (scl_sync[SyncStages-1] & scl_hist[1]) |
                  (scl_hist[0] & scl_hist[1]);
      sda_f    <= (sda_sync[SyncStages-1] & sda_hist[0]) | (sda_sync[SyncStages-1] & sda_hist[1]) |
                  (sda_hist[0] & sda_hist[1]);
    end
  end
`else
  assign scl_f = scl_sync[SyncStages-1];
  assign sda_f = sda_sync[SyncStages-1];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  // SCL must be high in both samples so an SDA change racing an SCL edge is not a condition.
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       bit_done;
  logic       first_pend;
  logic       tx_acked;
  logic       addr_hit;

  assign addr_hit = (shreg[7:1] == TargetAddr) && (TargetAddr != 7'd0);
  assign busy_o   = (state != S_IDLE) && (state != S_WAIT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      shreg      <= 8'h00;
      bit_cnt    <= 3'd0;
      bit_done   <= 1'b0;
      first_pend <= 1'b0;
      tx_acked   <= 1'b0;
      scl_o      <= 1'b1;
      sda_o      <= 1'b1;
      rx_data_o  <= 8'h00;
      rx_first_o <= 1'b0;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      stop_o     <= 1'b0;
      nak_o      <= 1'b0;
    end else begin
      stop_o     <= 1'b0;
      nak_o      <= 1'b0;
      tx_ready_o <= 1'b0;
      // Handshake runs in every state so a held byte drains even when disabled.
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;

      if (!enable_i) begin
        state <= S_IDLE;
        scl_o <= 1'b1;
        sda_o <= 1'b1;
      end else if (start_det) begin
        state    <= S_ADDR;
        bit_cnt  <= 3'd0;
        bit_done <= 1'b0;
        scl_o    <= 1'b1;
        sda_o    <= 1'b1;
      end else if (stop_det) begin
        state  <= S_IDLE;
        scl_o  <= 1'b1;
        sda_o  <= 1'b1;
        stop_o <= busy_o;
      end else begin
        case (state)
          S_ADDR, S_RX_BYTE: begin
            if (scl_rise && !bit_done) begin
              shreg    <= {shreg[6:0], sda_f};
              bit_cnt  <= bit_cnt + 3'd1;
              bit_done <= (bit_cnt == 3'd7);
            end else if (scl_fall && bit_done) begin
              if (state == S_ADDR) begin
                if (addr_hit) begin
                  state <= S_ADDR_ACK;
                  sda_o <= 1'b0;
                end else begin
                  state <= S_WAIT;
                end
              end else if (!rx_valid_o) begin
                rx_data_o  <= shreg;
                rx_valid_o <= 1'b1;
                rx_first_o <= first_pend;
                first_pend <= 1'b0;
                sda_o      <= 1'b0;
                state      <= S_RX_ACK;
              end else begin
                // Previous byte still unread: hold the ACK clock low.
                scl_o <= 1'b0;
                state <= S_RX_STALL;
              end
            end
          end
          S_RX_STALL: begin
            if (!rx_valid_o) begin
              rx_data_o  <= shreg;
              rx_valid_o <= 1'b1;
              rx_first_o <= first_pend;
              first_pend <= 1'b0;
              sda_o      <= 1'b0;
              scl_o      <= 1'b1;
              state      <= S_RX_ACK;
            end
          end
          S_ADDR_ACK, S_RX_ACK: begin
            if (scl_fall) begin
              sda_o    <= 1'b1;
              bit_cnt  <= 3'd0;
              bit_done <= 1'b0;
              if (state == S_RX_ACK || !shreg[0]) begin
                state <= S_RX_BYTE;
                if (state == S_ADDR_ACK) first_pend <= 1'b1;
              end else begin
                state <= S_TX_LOAD;
              end
            end
          end
          S_TX_LOAD: begin
            if (tx_valid_i) begin
              tx_ready_o <= 1'b1;
              shreg      <= tx_data_i;
              sda_o      <= tx_data_i[7];
              scl_o      <= 1'b1;
              bit_cnt    <= 3'd0;
              bit_done   <= 1'b0;
              state      <= S_TX_BYTE;
            end else begin
              scl_o <= 1'b0;
            end
          end
          S_TX_BYTE: begin
            // MSB is already on SDA; each fall presents the next bit, the 8th fall ends the byte.
            if (scl_fall) begin
              if (bit_done) begin
                sda_o    <= 1'b1;
                tx_acked <= 1'b0;
                state    <= S_TX_ACK;
              end else begin
                sda_o    <= shreg[6];
                shreg    <= {shreg[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
                bit_done <= (bit_cnt == 3'd6);
              end
            end
          end
          S_TX_ACK: begin
            if (scl_rise) begin
              if (sda_f) begin
                nak_o <= 1'b1;
                state <= S_WAIT;
              end else begin
                tx_acked <= 1'b1;
              end
            end else if (scl_fall && tx_acked) begin
              state <= S_TX_LOAD;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
